// File: rtl/taillight_monitor.sv
// taillight_monitor: decodes the left/right tail-light patterns produced by the
// light controller into turn and brake intent, and flags illegal patterns or
// illegal pattern transitions.
//
// Each side runs an identical tracker (OFF / TURN / STEADY) built from the
// previous sample, a saturating hold counter and a flag marking that the
// current 001/011 run is part of a clean turn sequence.
//
// HOLD_CYCLES must be greater than STEP_CYCLES.
//
// Optional feature: define TAILLIGHT_MON_ERR_CNT_EN to build the saturating
// 8-bit error counter. Without it, error_count is tied to zero.
module taillight_monitor #(
  parameter int STEP_CYCLES = 1,
  parameter int HOLD_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] left_taillight_control,
  input  logic [2:0] right_taillight_control,
  input  logic       err_clear,
  output logic       turn_left_detected,
  output logic       turn_right_detected,
  output logic       brake_detected,
  output logic       seq_error,
  output logic       err_sticky,
  output logic [7:0] error_count
);

  localparam int            HW     = $clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0] STEP_L = HW'(STEP_CYCLES);
  localparam logic [HW-1:0] HOLD_L = HW'(HOLD_CYCLES);

  typedef enum logic [1:0] {
    TRK_OFF    = 2'd0,
    TRK_TURN   = 2'd1,
    TRK_STEADY = 2'd2
  } trk_state_e;

  // Complete per-side tracker state.
  typedef struct packed {
    trk_state_e    state;
    logic [2:0]    prev;    // last sampled pattern
    logic [HW-1:0] hold;    // consecutive identical samples, saturating
    logic          seq_ok;  // current 001/011 run belongs to a clean sequence
  } trk_t;

  localparam trk_t TRK_RESET = '{state: TRK_OFF, prev: 3'b000, hold: '0, seq_ok: 1'b0};

  // One tracker step: given the current state and the new sample, return the
  // next state and report whether the sample is illegal.
  function automatic trk_t trk_next(input trk_t cur, input logic [2:0] pat,
                                    output logic bad);
    trk_t          nxt;
    logic [HW-1:0] run;
    logic          turn_done;

    if (pat != cur.prev)       run = HW'(1);
    else if (cur.hold == HOLD_L) run = HOLD_L;
    else                       run = cur.hold + HW'(1);

    case (pat)
      3'b010, 3'b100, 3'b101, 3'b110: bad = 1'b1;
      3'b011:  bad = (cur.prev != 3'b001) && (cur.prev != 3'b011);
      3'b111:  bad = (cur.prev == 3'b001);
      default: bad = 1'b0;
    endcase
    // Intermediate turn steps must not linger longer than one step time.
    if ((pat == 3'b001 || pat == 3'b011) && run > STEP_L) bad = 1'b1;

    // 111 closes a turn only if the 011 run before it was clean and was
    // itself entered from a clean 001 run.
    turn_done = (pat == 3'b111) && (cur.prev == 3'b011) && cur.seq_ok;

    nxt.prev   = pat;
    nxt.hold   = run;
    nxt.seq_ok = !bad && ((pat == 3'b001) || (pat == 3'b011 && cur.seq_ok));

    nxt.state = cur.state;
    if (bad)
      nxt.state = TRK_OFF;
    else if (pat == 3'b111 && run == HOLD_L)
      nxt.state = TRK_STEADY;
    else if (turn_done)
      nxt.state = TRK_TURN;
    else if (cur.state == TRK_STEADY && pat != 3'b111)
      nxt.state = TRK_OFF;
    else if (cur.state == TRK_TURN && pat == 3'b000 && run > STEP_L)
      nxt.state = TRK_OFF;
    return nxt;
  endfunction

  trk_t left_q, right_q;
  trk_t left_d, right_d;
  logic left_bad, right_bad;
  logic err_any;
  logic left_on, right_on;

  // Next-state decode for both trackers.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path can
    // leave it unassigned and infer a latch.
    left_bad  = 1'b0;
    right_bad = 1'b0;
    left_d    = trk_next(left_q,  left_taillight_control,  left_bad);
    right_d   = trk_next(right_q, right_taillight_control, right_bad);
  end

  assign err_any  = left_bad | right_bad;
  assign left_on  = (left_d.state  == TRK_TURN) || (left_d.state  == TRK_STEADY);
  assign right_on = (right_d.state == TRK_TURN) || (right_d.state == TRK_STEADY);

  // Tracker state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples values from before the edge, independent of statement order.
    if (!rst_n) begin
      left_q  <= TRK_RESET;
      right_q <= TRK_RESET;
    end else begin
      left_q  <= left_d;
      right_q <= right_d;
    end
  end

  // Registered decode outputs, updated on the same edge as the trackers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      turn_left_detected  <= 1'b0;
      turn_right_detected <= 1'b0;
      brake_detected      <= 1'b0;
      seq_error           <= 1'b0;
      err_sticky          <= 1'b0;
    end else begin
      turn_left_detected  <= (left_d.state  == TRK_TURN);
      turn_right_detected <= (right_d.state == TRK_TURN);
      brake_detected      <= ((left_d.state  == TRK_STEADY) && right_on) ||
                             ((right_d.state == TRK_STEADY) && left_on);
      seq_error           <= err_any;
      // A new error beats a coincident clear.
      if (err_any)        err_sticky <= 1'b1;
      else if (err_clear) err_sticky <= 1'b0;
    end
  end

`ifdef TAILLIGHT_MON_ERR_CNT_EN
  logic [7:0] err_cnt_q;

  // Saturating error count; an error coincident with a clear restarts at 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_cnt_q <= 8'd0;
    else if (err_any)
      err_cnt_q <= err_clear ? 8'd1 : ((err_cnt_q == 8'hFF) ? 8'hFF : err_cnt_q + 8'd1);
    else if (err_clear)
      err_cnt_q <= 8'd0;
  end

  assign error_count = err_cnt_q;
`else
  assign error_count = 8'd0;
`endif

endmodule

// File: tb/tb_taillight_monitor.sv
// tb_taillight_monitor: table-driven vectors, hand-written multi-cycle
// sequences and randomized stimulus compared against a history-based model.
module tb_taillight_monitor;

  localparam int STEP = 1;
  localparam int HOLD = 2;
`ifdef TAILLIGHT_MON_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  localparam int M_OFF = 0, M_TURN = 1, M_STEADY = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] lt, rt;
  logic       err_clear;
  logic       tl, tr, br, se, st;
  logic [7:0] ec;

  int checks = 0;
  int failures = 0;

  taillight_monitor #(.STEP_CYCLES(STEP), .HOLD_CYCLES(HOLD)) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .left_taillight_control  (lt),
    .right_taillight_control (rt),
    .err_clear               (err_clear),
    .turn_left_detected      (tl),
    .turn_right_detected     (tr),
    .brake_detected          (br),
    .seq_error               (se),
    .err_sticky              (st),
    .error_count             (ec)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int exp_cnt(input int n);
    return CNT_EN ? n : 0;
  endfunction

  // ---------------- reference model: full sample history per side ----------
  logic [2:0] hist [2][$];
  bit         hleg [2][$];
  int         m_st [2];
  bit         m_se, m_sticky;
  int         m_cnt;

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      hist[s].delete();
      hleg[s].delete();
      m_st[s] = M_OFF;
    end
    m_se = 0; m_sticky = 0; m_cnt = 0;
  endtask

  task automatic model_step(input logic [2:0] lp, input logic [2:0] rp, input bit clr);
    bit ill [2];
    for (int s = 0; s < 2; s++) begin
      logic [2:0] p, prev;
      int run, n, i;
      bit bad, done, ok;
      p    = (s == 0) ? lp : rp;
      n    = hist[s].size();
      prev = (n > 0) ? hist[s][n-1] : 3'b000;
      run  = 1;
      i    = n - 1;
      while (i >= 0 && hist[s][i] == p) begin run++; i--; end
      bad = (p inside {3'b010, 3'b100, 3'b101, 3'b110});
      if (p == 3'b011 && !(prev inside {3'b001, 3'b011})) bad = 1;
      if (prev == 3'b001 && p == 3'b111) bad = 1;
      if ((p == 3'b001 || p == 3'b011) && run > STEP) bad = 1;
      // Turn completes when the trailing history is a clean 001 run then a
      // clean 011 run, and this sample is 111.
      done = 0;
      if (!bad && p == 3'b111 && prev == 3'b011) begin
        ok = 1;
        i  = n - 1;
        while (i >= 0 && hist[s][i] == 3'b011) begin ok = ok & hleg[s][i]; i--; end
        if (i >= 0 && hist[s][i] == 3'b001) begin
          while (i >= 0 && hist[s][i] == 3'b001) begin ok = ok & hleg[s][i]; i--; end
          done = ok;
        end
      end
      if (bad)                                         m_st[s] = M_OFF;
      else if (p == 3'b111 && run >= HOLD)             m_st[s] = M_STEADY;
      else if (done)                                   m_st[s] = M_TURN;
      else if (m_st[s] == M_STEADY && p != 3'b111)     m_st[s] = M_OFF;
      else if (m_st[s] == M_TURN && p == 3'b000 && run > STEP) m_st[s] = M_OFF;
      hist[s].push_back(p);
      hleg[s].push_back(!bad);
      ill[s] = bad;
    end
    m_se = ill[0] | ill[1];
    if (m_se)     m_sticky = 1;
    else if (clr) m_sticky = 0;
    if (CNT_EN) begin
      if (m_se)     m_cnt = clr ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
      else if (clr) m_cnt = 0;
    end
  endtask

  task automatic model_compare(input string tag);
    bit m_br;
    m_br = (m_st[0] == M_STEADY && m_st[1] != M_OFF) || (m_st[1] == M_STEADY && m_st[0] != M_OFF);
    check({tag, ".turn_left"},  tl, (m_st[0] == M_TURN));
    check({tag, ".turn_right"}, tr, (m_st[1] == M_TURN));
    check({tag, ".brake"},      br, m_br);
    check({tag, ".seq_error"},  se, m_se);
    check({tag, ".err_sticky"}, st, m_sticky);
    check({tag, ".error_count"}, ec, m_cnt);
  endtask

  // ---------------- stimulus helpers ----------------------------------------
  // Apply one sample; outputs are observed 1 ns after the sampling edge.
  task automatic drive(input logic [2:0] l, input logic [2:0] r, input bit clr);
    lt = l; rt = r; err_clear = clr;
    @(posedge clk);
    model_step(l, r, clr);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; lt = 3'b000; rt = 3'b000; err_clear = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [2:0] next_pat(input logic [2:0] cur);
    int r;
    r = $urandom_range(99);
    if (r < 60) begin
      case (cur)
        3'b000:  return 3'b001;
        3'b001:  return 3'b011;
        3'b011:  return 3'b111;
        default: return 3'b000;
      endcase
    end
    else if (r < 75) return cur;
    else if (r < 88) return 3'b111;
    else if (r < 94) return 3'b000;
    return 3'($urandom_range(7));
  endfunction

  // ---------------- vector table --------------------------------------------
  typedef struct {
    logic [2:0] l, r;
    bit clr;
    bit tl, tr, br, se, st;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [2:0] l, input logic [2:0] r, input bit clr,
                     input bit etl, input bit etr, input bit ebr, input bit ese, input bit est);
    vec_t v;
    v.l = l; v.r = r; v.clr = clr;
    v.tl = etl; v.tr = etr; v.br = ebr; v.se = ese; v.st = est;
    vecs.push_back(v);
  endtask

  initial begin
    logic [2:0] pl, pr;
    bit seen;

    rst_n = 1'b0; lt = 3'b000; rt = 3'b000; err_clear = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset.turn_left", tl, 0);
    check("reset.turn_right", tr, 0);
    check("reset.brake", br, 0);
    check("reset.seq_error", se, 0);
    check("reset.err_sticky", st, 0);
    check("reset.error_count", ec, 0);
    @(negedge clk);
    rst_n = 1'b1;

    //   left    right  clr  tl tr br se st
    add(3'b000, 3'b000, 0,   0, 0, 0, 0, 0);
    add(3'b001, 3'b000, 0,   0, 0, 0, 0, 0);
    add(3'b011, 3'b000, 0,   0, 0, 0, 0, 0);
    add(3'b111, 3'b000, 0,   1, 0, 0, 0, 0);
    add(3'b000, 3'b000, 0,   1, 0, 0, 0, 0);
    add(3'b001, 3'b000, 0,   1, 0, 0, 0, 0);
    add(3'b011, 3'b000, 0,   1, 0, 0, 0, 0);
    add(3'b111, 3'b000, 0,   1, 0, 0, 0, 0);
    add(3'b000, 3'b000, 0,   1, 0, 0, 0, 0);
    add(3'b000, 3'b000, 0,   0, 0, 0, 0, 0);
    add(3'b111, 3'b111, 0,   0, 0, 0, 0, 0);
    add(3'b111, 3'b111, 0,   0, 0, 1, 0, 0);
    add(3'b111, 3'b111, 0,   0, 0, 1, 0, 0);
    add(3'b000, 3'b111, 0,   0, 0, 0, 0, 0);
    add(3'b010, 3'b111, 0,   0, 0, 0, 1, 1);
    add(3'b000, 3'b111, 0,   0, 0, 0, 0, 1);
    add(3'b001, 3'b111, 0,   0, 0, 0, 0, 1);
    add(3'b001, 3'b111, 0,   0, 0, 0, 1, 1);
    add(3'b011, 3'b111, 0,   0, 0, 0, 0, 1);
    add(3'b111, 3'b111, 0,   0, 0, 0, 0, 1);
    add(3'b111, 3'b111, 0,   0, 0, 1, 0, 1);
    add(3'b111, 3'b111, 1,   0, 0, 1, 0, 0);
    add(3'b011, 3'b111, 1,   0, 0, 0, 1, 1);
    add(3'b000, 3'b000, 0,   0, 0, 0, 0, 1);

    for (int k = 0; k < vecs.size(); k++) begin
      drive(vecs[k].l, vecs[k].r, vecs[k].clr);
      check($sformatf("vec%0d.turn_left", k),  tl, vecs[k].tl);
      check($sformatf("vec%0d.turn_right", k), tr, vecs[k].tr);
      check($sformatf("vec%0d.brake", k),      br, vecs[k].br);
      check($sformatf("vec%0d.seq_error", k),  se, vecs[k].se);
      check($sformatf("vec%0d.err_sticky", k), st, vecs[k].st);
    end

    // Left cycling 000,001,011,111 for 20 cycles.
    do_reset();
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      case (i % 4)
        0: drive(3'b000, 3'b000, 0);
        1: drive(3'b001, 3'b000, 0);
        2: drive(3'b011, 3'b000, 0);
        default: drive(3'b111, 3'b000, 0);
      endcase
      check($sformatf("cycle20.turn_left%0d", i), tl, (i >= 3));
      seen = seen | tr | br | se;
    end
    check("cycle20.no_right_brake_err", seen, 0);

    // Right sequencing with left steady, then left drops to 000.
    do_reset();
    drive(3'b111, 3'b001, 0);
    drive(3'b111, 3'b011, 0);
    drive(3'b111, 3'b111, 0);
    check("steady_turn.brake", br, 1);
    check("steady_turn.turn_right", tr, 1);
    check("steady_turn.turn_left", tl, 0);
    drive(3'b000, 3'b000, 0);
    check("steady_turn.brake_drop1", br, 0);
    check("steady_turn.turn_right_hold", tr, 1);
    drive(3'b000, 3'b001, 0);
    check("steady_turn.brake_drop2", br, 0);

    // Two separate errors.
    do_reset();
    drive(3'b001, 3'b000, 0);
    drive(3'b111, 3'b000, 0);
    check("two_err.first_pulse", se, 1);
    drive(3'b000, 3'b110, 0);
    check("two_err.second_pulse", se, 1);
    drive(3'b000, 3'b000, 0);
    check("two_err.pulse_end", se, 0);
    check("two_err.sticky", st, 1);
    check("two_err.count", ec, exp_cnt(2));

    // Left turn handed over to right turn.
    do_reset();
    drive(3'b001, 3'b000, 0);
    drive(3'b011, 3'b000, 0);
    drive(3'b111, 3'b000, 0);
    check("handover.left_on", tl, 1);
    drive(3'b000, 3'b001, 0);
    check("handover.left_still_on", tl, 1);
    check("handover.no_err1", se, 0);
    drive(3'b000, 3'b011, 0);
    check("handover.left_off", tl, 0);
    check("handover.no_err2", se, 0);
    drive(3'b000, 3'b111, 0);
    check("handover.right_on", tr, 1);
    check("handover.no_err3", se, 0);

    // Asynchronous reset mid-sequence discards the partial run.
    do_reset();
    drive(3'b001, 3'b010, 0);
    check("midreset.err", se, 1);
    drive(3'b011, 3'b000, 0);
    drive(3'b111, 3'b000, 0);
    check("midreset.turn_before", tl, 1);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("midreset.turn_left", tl, 0);
    check("midreset.sticky", st, 0);
    check("midreset.count", ec, 0);
    check("midreset.brake", br, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(3'b111, 3'b000, 0);
    check("midreset.no_turn_after", tl, 0);
    check("midreset.no_err_after", se, 0);

    // Counter saturation, clear, simultaneous errors, clear-vs-error.
    do_reset();
    for (int i = 0; i < 260; i++) drive(3'b010, 3'b000, 0);
    check("sat.count", ec, exp_cnt(255));
    check("sat.seq_error", se, 1);
    check("sat.sticky", st, 1);
    drive(3'b000, 3'b000, 1);
    check("sat.clear_count", ec, 0);
    check("sat.clear_sticky", st, 0);
    check("sat.clear_seq_error", se, 0);
    drive(3'b010, 3'b101, 0);
    check("both.seq_error", se, 1);
    check("both.count", ec, exp_cnt(1));
    drive(3'b000, 3'b000, 0);
    check("both.pulse_end", se, 0);
    drive(3'b110, 3'b000, 1);
    check("clr_vs_err.sticky", st, 1);
    check("clr_vs_err.count", ec, exp_cnt(1));

    // Randomized run against the model, with occasional resets.
    do_reset();
    pl = 3'b000; pr = 3'b000;
    for (int i = 0; i < 2000; i++) begin
      if (i % 500 == 499) begin
        do_reset();
        pl = 3'b000; pr = 3'b000;
      end
      pl = next_pat(pl);
      pr = next_pat(pr);
      drive(pl, pr, ($urandom_range(19) == 0));
      model_compare($sformatf("rand%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
